// File: rtl/dct_pkg.sv
// Shared definitions for the sample-serial 8-point DCT engine:
// point count, default widths, FSM state encoding and the Q1.14 cosine ROM.
package dct_pkg;

  localparam int N_POINTS      = 8;
  localparam int DATA_W_DEF    = 16;
  localparam int FRAC_W_DEF    = 4;
  localparam int COEF_W_DEF    = 16;
  localparam int COEF_FRAC_DEF = 14;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    MAC  = 2'd1,
    RES  = 2'd2,
    OUT  = 2'd3
  } state_t;

  typedef logic signed [COEF_W_DEF-1:0] coef_t;

  // C[k][n] = round(2^14 * a(k) * cos((2n+1)k*pi/16)), a(0)=1/sqrt(8), a(k>0)=1/2.
  // Row k is indexed first; odd rows are antisymmetric, even rows symmetric.
  localparam coef_t COS_ROM [N_POINTS][N_POINTS] = '{
    '{ 16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793},
    '{ 16'sd8035,  16'sd6811,  16'sd4551,  16'sd1598, -16'sd1598, -16'sd4551, -16'sd6811, -16'sd8035},
    '{ 16'sd7568,  16'sd3135, -16'sd3135, -16'sd7568, -16'sd7568, -16'sd3135,  16'sd3135,  16'sd7568},
    '{ 16'sd6811, -16'sd1598, -16'sd8035, -16'sd4551,  16'sd4551,  16'sd8035,  16'sd1598, -16'sd6811},
    '{ 16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,  16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793},
    '{ 16'sd4551, -16'sd8035,  16'sd1598,  16'sd6811, -16'sd6811, -16'sd1598,  16'sd8035, -16'sd4551},
    '{ 16'sd3135, -16'sd7568,  16'sd7568, -16'sd3135, -16'sd3135,  16'sd7568, -16'sd7568,  16'sd3135},
    '{ 16'sd1598, -16'sd4551,  16'sd6811, -16'sd8035,  16'sd8035, -16'sd6811,  16'sd4551, -16'sd1598}
  };

  // ROM lookup by (row, column).
  function automatic coef_t rom_coef(input logic [2:0] row, input logic [2:0] col);
    return COS_ROM[row][col];
  endfunction

endpackage

// File: rtl/dct_mac_unit.sv
// Single signed multiply-accumulate with round-half-up rescale and saturation.
// The result/sat outputs are combinational views of the current accumulator.
module dct_mac_unit #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14,
  parameter int ACC_W     = DATA_W + COEF_W + 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [DATA_W-1:0] result,
  output logic                     sat
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  acc_reg;
  logic signed [ACC_W-1:0]  rounded;
  logic signed [ACC_W-1:0]  shifted;

  assign product = sample * coef;
  assign rounded = acc_reg + HALF;
  assign shifted = rounded >>> COEF_FRAC;

  // Accumulator: cleared at the start of each output, sign-extended product added per MAC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_reg + {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
    end
  end

  // Clip the rescaled sum to the output word range and flag any clipping.
  always_comb begin
    result = shifted[DATA_W-1:0];
    sat    = 1'b0;
    if (shifted > OUT_MAX) begin
      result = OUT_MAX[DATA_W-1:0];
      sat    = 1'b1;
    end else if (shifted < OUT_MIN) begin
      result = OUT_MIN[DATA_W-1:0];
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/dct8_stream_mac.sv
// Sample-serial 8-point DCT-II / DCT-III engine built around one MAC.
// Loads 8 samples, then produces 8 outputs, each from 8 MAC cycles plus a result cycle.
module dct8_stream_mac
  import dct_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAC_W    = FRAC_W_DEF,
  parameter int COEF_W    = COEF_W_DEF,
  parameter int COEF_FRAC = COEF_FRAC_DEF,
  parameter int ACC_W     = DATA_W + COEF_W + 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_inv,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              m_sat
);

  // Reject parameter sets that could overflow the accumulator or make no sense.
  if (ACC_W < DATA_W + COEF_W + 3 || FRAC_W >= DATA_W) begin : g_param_check
    $error("dct8_stream_mac: illegal ACC_W/FRAC_W parameters");
  end

  state_t                    state_reg, state_next;
  logic [DATA_W-1:0]         samp_buf [N_POINTS];
  logic [2:0]                in_idx_reg;
  logic [2:0]                k_reg;
  logic [2:0]                n_reg;
  logic                      inv_reg;
  logic                      s_fire;
  logic                      mac_clr;
  logic                      mac_en;
  coef_t                     rom_word;
  logic signed [COEF_W-1:0]  coef;
  logic signed [DATA_W-1:0]  mac_result;
  logic                      mac_sat;
  logic [DATA_W-1:0]         m_data_reg;
  logic                      m_last_reg;
  logic                      m_sat_reg;

  assign s_ready = (state_reg == LOAD);
  assign m_valid = (state_reg == OUT);
  assign s_fire  = s_valid && s_ready;
  assign m_data  = m_data_reg;
  assign m_last  = m_last_reg;
  assign m_sat   = m_sat_reg;

  // Forward mode walks ROM row k; inverse mode walks column k (transposed matrix).
  assign rom_word = inv_reg ? rom_coef(n_reg, k_reg) : rom_coef(k_reg, n_reg);
  assign coef     = COEF_W'(rom_word);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= LOAD;
    else        state_reg <= state_next;
  end

  // Next-state logic and MAC control strobes.
  always_comb begin
    state_next = state_reg;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    case (state_reg)
      LOAD: begin
        if (s_fire && in_idx_reg == 3'd7) begin
          state_next = MAC;
          mac_clr    = 1'b1;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (n_reg == 3'd7) state_next = RES;
      end
      RES: state_next = OUT;
      OUT: begin
        if (m_ready) begin
          mac_clr    = 1'b1;
          state_next = (k_reg == 3'd7) ? LOAD : MAC;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // Load index, mode latch and the output/product counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_idx_reg <= '0;
      k_reg      <= '0;
      n_reg      <= '0;
      inv_reg    <= 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (s_fire) begin
            if (in_idx_reg == 3'd0) inv_reg <= s_inv;
            in_idx_reg <= in_idx_reg + 3'd1;
            k_reg      <= '0;
            n_reg      <= '0;
          end
        end
        MAC:     n_reg <= n_reg + 3'd1;
        OUT:     if (m_ready) k_reg <= k_reg + 3'd1;
        default: ;
      endcase
    end
  end

  // Sample buffer: written only on an accepted input transfer.
  always_ff @(posedge clk) begin
    if (s_fire) samp_buf[in_idx_reg] <= s_data;
  end

  // Output register: captured in the result cycle, held through the OUT handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_reg <= '0;
      m_last_reg <= 1'b0;
      m_sat_reg  <= 1'b0;
    end else if (state_reg == RES) begin
      m_data_reg <= mac_result;
      m_last_reg <= (k_reg == 3'd7);
      m_sat_reg  <= mac_sat;
    end
  end

  dct_mac_unit #(
    .DATA_W    (DATA_W),
    .COEF_W    (COEF_W),
    .COEF_FRAC (COEF_FRAC),
    .ACC_W     (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (mac_clr),
    .en     (mac_en),
    .sample ($signed(samp_buf[n_reg])),
    .coef   (coef),
    .result (mac_result),
    .sat    (mac_sat)
  );

endmodule

// File: tb/tb_dct8_stream_mac.sv
// Scoreboard bench for dct8_stream_mac: expectations come from a bit-exact
// integer model (coefficients built from $cos) plus a double-precision reference.
module tb_dct8_stream_mac;

  localparam real PI = 3.14159265358979323846;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        s_inv;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;
  logic        m_sat;

  typedef struct {
    int  data;
    bit  last;
    bit  sat;
    real ref_val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   out_idx  = 0;
  int   got_hist [8];
  bit   stall_arm = 0;

  dct8_stream_mac dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_inv   (s_inv),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_sat   (m_sat)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic real alpha(input int k);
    return (k == 0) ? 1.0 / $sqrt(8.0) : 0.5;
  endfunction

  function automatic int coef_model(input int k, input int n);
    real v;
    v = 16384.0 * alpha(k) * $cos(real'((2*n+1)*k) * PI / 16.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  task automatic push_expect(input int x[8], input bit inv);
    for (int k = 0; k < 8; k++) begin
      longint acc = 0;
      longint r;
      real    rr = 0.0;
      exp_t   e;
      for (int n = 0; n < 8; n++) begin
        acc += longint'(x[n]) * longint'(inv ? coef_model(n, k) : coef_model(k, n));
        if (inv) rr += real'(x[n]) * alpha(n) * $cos(real'((2*k+1)*n) * PI / 16.0);
        else     rr += real'(x[n]) * alpha(k) * $cos(real'((2*n+1)*k) * PI / 16.0);
      end
      r = (acc + 64'sd8192) >>> 14;
      e.sat = 0;
      if (r > 32767)       begin r = 32767;  e.sat = 1; end
      else if (r < -32768) begin r = -32768; e.sat = 1; end
      e.data    = int'(r);
      e.last    = (k == 7);
      e.ref_val = rr;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_block(input int x[8], input bit inv);
    push_expect(x, inv);
    for (int i = 0; i < 8; i++) begin
      int cnt = 0;
      s_valid = 1;
      s_data  = 16'(x[i]);
      s_inv   = (i == 0) ? inv : !inv;
      @(negedge clk);
      while (!s_ready && cnt < 2000) begin
        @(negedge clk);
        cnt++;
      end
      if (!s_ready) check("s_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
    end
    s_valid = 0;
  endtask

  task automatic drain(input int budget);
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < budget) begin
      @(posedge clk);
      cnt++;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        real  d;
        e = exp_q.pop_front();
        $display("out %0d: data=%0d last=%0d sat=%0d (model %0d)", out_idx,
                 $signed(m_data), m_last, m_sat, e.data);
        check("m_data", longint'($signed(m_data)), e.data);
        check("m_last", m_last, e.last);
        check("m_sat", m_sat, e.sat);
        if (!e.sat) begin
          d = real'($signed(m_data)) - e.ref_val;
          check("dbl_tol", (d <= 1.0 && d >= -1.0) ? 1 : 0, 1);
        end
        got_hist[out_idx] = int'($signed(m_data));
        out_idx = (out_idx + 1) % 8;
      end
    end
  end

  // Backpressure driver: stalls output index 3 for 20 cycles when armed.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_arm && m_valid && out_idx == 3) begin
        m_ready = 0;
        repeat (20) begin
          @(negedge clk);
          if (exp_q.size() > 0) check("stall_data", longint'($signed(m_data)), exp_q[0].data);
          check("stall_s_ready", s_ready, 0);
          check("stall_m_valid", m_valid, 1);
        end
        @(posedge clk);
        #1;
        m_ready   = 1;
        stall_arm = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int x[8];
    int cnt;
    rst_n   = 0;
    s_valid = 0;
    s_data  = '0;
    s_inv   = 0;
    m_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_sat", m_sat, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Forward DC, with junk presented while s_ready is low.
    for (int i = 0; i < 8; i++) x[i] = 256;
    send_block(x, 0);
    s_valid = 1;
    s_data  = 16'h5A5A;
    s_inv   = 1;
    repeat (5) @(posedge clk);
    #1;
    check("busy_s_ready", s_ready, 0);
    s_valid = 0;
    drain(400);
    check("dc_out0", got_hist[0], 724);
    for (int i = 1; i < 8; i++) check("dc_zero", got_hist[i], 0);

    // Forward ramp.
    x = '{256, 320, 240, 480, 192, 208, 192, 208};
    send_block(x, 0);
    drain(400);
    check("ramp_out0", got_hist[0], 741);

    // Inverse of a pure DC coefficient.
    x = '{724, 0, 0, 0, 0, 0, 0, 0};
    send_block(x, 1);
    drain(400);
    for (int i = 0; i < 8; i++) check("inv_flat", got_hist[i], 256);

    // Saturation on the DC term.
    for (int i = 0; i < 8; i++) x[i] = 32767;
    send_block(x, 0);
    drain(400);
    check("sat_out0", got_hist[0], 32767);

    // Backpressure on output 3 of the ramp block.
    stall_arm = 1;
    x = '{256, 320, 240, 480, 192, 208, 192, 208};
    send_block(x, 0);
    drain(600);
    check("stall_done", stall_arm, 0);

    // Random blocks, submitted back to back.
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(0, 2048)) - 1024;
      send_block(x, 1'($urandom_range(0, 1)));
    end
    drain(1200);

    // Mid-block reset during the MAC phase of output 2.
    x = '{256, 320, 240, 480, 192, 208, 192, 208};
    send_block(x, 0);
    cnt = 0;
    while (out_idx != 2 && cnt < 1000) begin
      @(posedge clk);
      cnt++;
    end
    check("reach_out2", out_idx, 2);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    check("mrst_m_valid", m_valid, 0);
    check("mrst_s_ready", s_ready, 1);
    check("mrst_m_data", m_data, 0);
    exp_q.delete();
    out_idx = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) x[i] = 256;
    send_block(x, 0);
    drain(400);
    check("post_rst_dc0", got_hist[0], 724);
    for (int i = 1; i < 8; i++) check("post_rst_zero", got_hist[i], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
